bn_stream_sequencer: RTL and testbench
======================================

// Module: bn_stream_sequencer
// PURPOSE
//  Sequences one HxWxFILTERS activation frame (HWC order, channel fastest) into the batch-norm datapath.
//  Tracks channel/column/row counters and issues the per-channel mean/variance parameter-RAM read.
//  Presents each beat to the datapath in the cycle the parameter RAM returns that channel's data.
//  Reports frame done. Sits between the conv output stream and the BN datapath.
// PARAMETERS
//  DW       16   activation/parameter word width
//  H        256  frame rows
//  W        256  frame columns
//  FILTERS  64   channels per pixel; parameter RAM depth
//  CW       $clog2(FILTERS)  channel index width (derived, localparam)
// PORTS
//  clk          in   1    clock, rising edge
//  rst_n        in   1    asynchronous active-low reset
//  start        in   1    pulse: begin a frame (honoured only in IDLE)
//  busy         out  1    high in RUN or DRAIN
//  done         out  1    one-cycle pulse after the frame's last beat leaves
//  in_valid     in   1    activation beat valid
//  in_ready     out  1    block accepts beat
//  in_data      in   DW   activation
//  param_re     out  1    parameter RAM read enable
//  param_addr   out  CW   parameter RAM address (= channel of accepted beat)
//  dp_valid     out  1    beat valid toward datapath
//  dp_ready     in   1    datapath accepts beat
//  dp_data      out  DW   registered activation
//  dp_ch        out  CW   channel of dp_data
//  dp_last      out  1    beat is last of frame
// BEHAVIOUR
//  Reset: state=IDLE; counters=0; busy=0, done=0, in_ready=0, param_re=0, dp_valid=0, dp_data=0, dp_ch=0, dp_last=0.
//  FSM: IDLE -start-> RUN; RUN -last beat accepted-> DRAIN; DRAIN -dp_valid&&dp_ready-> DONE; DONE -> IDLE (1 cycle, done=1).
//  start in RUN/DRAIN/DONE ignored. start+in_valid in the IDLE cycle: beat not accepted (in_ready=0 in IDLE).
//  in_ready = (state==RUN) && (!dp_valid || dp_ready); accept = in_valid && in_ready.
//  param_re = accept; param_addr = ch counter (combinational). RAM: 1-cycle read latency, holds rdata until next re.
//  On accept: dp_data<=in_data, dp_ch<=ch, dp_last<=(ch==FILTERS-1 && col==W-1 && row==H-1), dp_valid<=1.
//  Else if dp_ready: dp_valid<=0. Latency in->dp: 1 cycle. Full throughput (1 beat/clk) when dp_ready held high.
//  dp_valid stall: dp_data/dp_ch/dp_last stable; param RAM not re-read, so rdata stays aligned.
//  Counters advance only on accept: ch wraps FILTERS-1->0 and increments col; col wraps W-1->0 and increments row;
//   row wraps H-1->0 with last beat; all counters 0 at frame start.
//  Accept and dp drain in the same cycle: new beat replaces old; dp_valid stays 1.
//  Async reset mid-frame: everything returns to reset values at once; partial frame discarded, no done.
//  Beats presented outside RUN are held off (in_ready=0), never dropped.
// CONFIGURATION
//  BN_STALL_CNT_EN defined: adds output stall_cnt[31:0].
//   stall_cnt counts cycles in RUN/DRAIN with dp_valid && !dp_ready.
//   Cleared to 0 on reset and on start accepted in IDLE; saturates at 32'hFFFFFFFF.
//  Not defined: port absent, no counter logic.
// TESTING (H=2, W=2, FILTERS=3, DW=16)
//  1 reset, start, 12 beats data=0..11, dp_ready=1 -> param_addr 0,1,2,0,1,2,...; dp_data/dp_ch follow 1 clk later;
//    dp_last only on beat 11; done pulses 2 clk after beat 11 accepted; busy low after done.
//  2 dp_ready=0 for 5 cycles after beat 4 -> in_ready=0; dp_data=4 held; single param_re for beat 4;
//    resume with no loss or duplication (stall_cnt=5 if BN_STALL_CNT_EN).
//  3 in_valid toggling 1/0 every cycle -> counters advance only on accept; output order 0..11 intact.
//  4 start asserted during RUN -> ignored, no counter reset; in_valid with no start -> in_ready stays 0.
//  5 rst_n low after beat 6 -> all outputs 0 immediately, no done; next start+12 beats -> normal frame from ch=0.
//  6 two back-to-back frames (start in cycle after done) -> second frame param_addr starts at 0, dp_last once per frame.

Source files
------------

// File: rtl/bn_stream_sequencer.sv
// rtl/bn_stream_sequencer.sv - HWC frame sequencer feeding the batch-norm datapath with per-channel param reads.
// Optional macro BN_STALL_CNT_EN adds the stall_cnt output.
module bn_stream_sequencer #(
  parameter int DW      = 16,
  parameter int H       = 256,
  parameter int W       = 256,
  parameter int FILTERS = 64,
  localparam int CW     = (FILTERS > 1) ? $clog2(FILTERS) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          busy,
  output logic          done,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          param_re,
  output logic [CW-1:0] param_addr,
`ifdef BN_STALL_CNT_EN
  output logic [31:0]   stall_cnt,
`endif
  output logic          dp_valid,
  input  logic          dp_ready,
  output logic [DW-1:0] dp_data,
  output logic [CW-1:0] dp_ch,
  output logic          dp_last
);

  localparam int CLW = (W > 1) ? $clog2(W) : 1;
  localparam int RW  = (H > 1) ? $clog2(H) : 1;
  localparam logic [CW-1:0]  CH_MAX  = CW'(FILTERS - 1);
  localparam logic [CLW-1:0] COL_MAX = CLW'(W - 1);
  localparam logic [RW-1:0]  ROW_MAX = RW'(H - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t         state, state_nxt;
  logic [CW-1:0]  ch;
  logic [CLW-1:0] col;
  logic [RW-1:0]  row;
  logic           accept;
  logic           frame_end;

  assign frame_end  = (ch == CH_MAX) && (col == COL_MAX) && (row == ROW_MAX);
  assign in_ready   = (state == RUN) && (!dp_valid || dp_ready);
  assign accept     = in_valid && in_ready;
  assign param_re   = accept;
  assign param_addr = ch;
  assign busy       = (state == RUN) || (state == DRAIN);
  assign done       = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (accept && frame_end) state_nxt = DRAIN;
      DRAIN:   if (dp_valid && dp_ready) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Channel is the fastest-moving index; col and row carry from it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch  <= '0;
      col <= '0;
      row <= '0;
    end else if (state == IDLE && start) begin
      ch  <= '0;
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (ch == CH_MAX) begin
        ch <= '0;
        if (col == COL_MAX) begin
          col <= '0;
          row <= (row == ROW_MAX) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end else begin
        ch <= ch + 1'b1;
      end
    end
  end

  // The output register only loads on accept, so a stall never re-reads the param RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dp_valid <= 1'b0;
      dp_data  <= '0;
      dp_ch    <= '0;
      dp_last  <= 1'b0;
    end else if (accept) begin
      dp_valid <= 1'b1;
      dp_data  <= in_data;
      dp_ch    <= ch;
      dp_last  <= frame_end;
    end else if (dp_ready) begin
      dp_valid <= 1'b0;
    end
  end

`ifdef BN_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (state == IDLE && start) begin
      stall_cnt <= '0;
    end else if (busy && dp_valid && !dp_ready && stall_cnt != 32'hFFFF_FFFF) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bn_stream_sequencer.sv
// tb/tb_bn_stream_sequencer.sv - randomized scoreboard bench for bn_stream_sequencer (H=2, W=2, FILTERS=3).
module tb_bn_stream_sequencer;
  localparam int DW = 16, H = 2, W = 2, FILTERS = 3, CW = 2, NBEAT = H * W * FILTERS;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, in_valid = 1'b0, dp_ready = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic busy, done, in_ready, param_re, dp_valid, dp_last;
  logic [CW-1:0] param_addr, dp_ch;
  logic [DW-1:0] dp_data;
`ifdef BN_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  bn_stream_sequencer #(.DW(DW), .H(H), .W(W), .FILTERS(FILTERS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .param_re(param_re), .param_addr(param_addr),
`ifdef BN_STALL_CNT_EN
    .stall_cnt(stall_cnt),
`endif
    .dp_valid(dp_valid), .dp_ready(dp_ready), .dp_data(dp_data), .dp_ch(dp_ch), .dp_last(dp_last)
  );

  always #5 clk = ~clk;

  // Parameter RAM model: one-cycle read, holds data until the next read.
  logic [DW-1:0] ram [4];
  logic [DW-1:0] rdata = '0;
  always @(posedge clk) if (param_re) rdata <= ram[param_addr];

  typedef struct { logic [DW-1:0] data; int ch; bit last; } beat_t;
  beat_t exp_q[$];

  int n_tests = 0, n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_param_re"}, param_re, 0);
    check({tag, "_dp_valid"}, dp_valid, 0);
    check({tag, "_dp_data"}, dp_data, 0);
    check({tag, "_dp_ch"}, dp_ch, 0);
    check({tag, "_dp_last"}, dp_last, 0);
  endtask

  // mode 0: full rate, data=index; 1: 5-cycle dp stall after beat 4;
  // 2: in_valid toggles; 3: random valid/ready with stray starts.
  task automatic run_frame(input int mode, input int abort_at);
    logic [DW-1:0] src [NBEAT];
    int idx = 0, cyc = 0, stall_left = 0, stall_model = 0, last_acc_cyc = 0;
    bit got_done = 0, pend_done = 0, held_valid = 0, tg = 0;
    beat_t held, e;
    for (int i = 0; i < NBEAT; i++) src[i] = (mode == 0) ? DW'(i) : DW'($urandom);
    exp_q.delete();

    @(posedge clk); #1;
    start = 1'b1; in_valid = 1'b1; in_data = src[0]; dp_ready = 1'b1;
    @(negedge clk);
    check("idle_start_in_ready", in_ready, 0);
    check("idle_done", done, 0);
    check("idle_busy", busy, 0);

    while (!got_done && cyc < 400) begin
      @(posedge clk); #1;
      if (abort_at != 0 && idx == abort_at) begin
        #2 rst_n = 1'b0;
        #1 check_zero_outputs("async_rst");
        @(negedge clk);
        rst_n = 1'b1; in_valid = 1'b0; start = 1'b0;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          check("post_rst_done", done, 0);
          check("post_rst_busy", busy, 0);
        end
        exp_q.delete();
        return;
      end
      start = 1'b0;
      in_data = src[(idx < NBEAT) ? idx : 0];
      case (mode)
        0: begin in_valid = (idx < NBEAT); dp_ready = 1'b1; end
        1: begin
          in_valid = (idx < NBEAT);
          dp_ready = (stall_left == 0);
          if (stall_left > 0) stall_left--;
        end
        2: begin tg = ~tg; in_valid = (idx < NBEAT) && tg; dp_ready = 1'b1; end
        default: begin
          in_valid = (idx < NBEAT) && ($urandom % 3 != 0);
          dp_ready = ($urandom % 4 != 0);
          start    = (idx < NBEAT) && ($urandom % 8 == 0);
        end
      endcase

      @(negedge clk);
      cyc++;
      if (held_valid) begin
        check("hold_data", dp_data, held.data);
        check("hold_ch", dp_ch, held.ch);
        check("hold_last", dp_last, held.last);
        held_valid = 0;
      end
      if (pend_done) begin
        check("done_pulse", done, 1);
        check("done_busy", busy, 0);
        if (mode == 0) check("done_latency", cyc - last_acc_cyc, 2);
`ifdef BN_STALL_CNT_EN
        check("stall_cnt", stall_cnt, stall_model);
`endif
        if (mode == 1) check("stall_cycles", stall_model, 5);
        got_done = 1;
      end else begin
        check("no_early_done", done, 0);
      end
      if (dp_valid && dp_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_dp_beat", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("dp_data", dp_data, e.data);
          check("dp_ch", dp_ch, e.ch);
          check("dp_last", dp_last, e.last);
          check("param_rdata", rdata, ram[e.ch]);
          if (e.last) pend_done = 1;
        end
      end
      if (dp_valid && !dp_ready) begin
        stall_model++;
        check("stall_in_ready", in_ready, 0);
        if (mode == 1) check("stall_data", dp_data, src[4]);
        held.data = dp_data; held.ch = dp_ch; held.last = dp_last;
        held_valid = 1;
      end
      if (in_valid && in_ready) begin
        check("param_re", param_re, 1);
        check("param_addr", param_addr, idx % FILTERS);
        e.data = src[idx]; e.ch = idx % FILTERS; e.last = (idx == NBEAT - 1);
        exp_q.push_back(e);
        if (idx == NBEAT - 1) last_acc_cyc = cyc;
        idx++;
        if (mode == 1 && idx == 5) stall_left = 5;
      end else begin
        check("param_re_idle", param_re, 0);
      end
    end
    if (!got_done) check("frame_timeout", 0, 1);
    check("frame_beats_left", exp_q.size(), 0);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) ram[i] = DW'($urandom);
    repeat (2) @(negedge clk);
    check_zero_outputs("reset");
    rst_n = 1'b1;
    in_valid = 1'b1; in_data = 16'h1234;
    repeat (3) begin
      @(negedge clk);
      check("idle_holdoff", in_ready, 0);
      check("idle_no_re", param_re, 0);
    end
    in_valid = 1'b0;

    run_frame(0, 0);
    run_frame(1, 0);
    run_frame(2, 0);
    run_frame(0, 7);
    run_frame(0, 0);
    run_frame(0, 0);
    for (int f = 0; f < 6; f++) run_frame(3, 0);

    @(posedge clk); #1;
    in_valid = 1'b1;
    @(negedge clk);
    check("end_idle_in_ready", in_ready, 0);
    check("end_idle_busy", busy, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
